// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared defaults and index-legality helper for the register file.
// Revision : 1.0
// ============================================================================
package regfile_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int REG_ZERO     = 0;

  // An index is legal when it names a real register that can hold state.
  function automatic logic idx_legal(input int idx, input int num_regs, input bit zero_reg);
    return (idx < num_regs) && !(zero_reg && (idx == REG_ZERO));
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module   : rf_read_port
// Brief    : One combinational read path with write bypass and hazard flag.
// Revision : 1.0
// ============================================================================
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [NUM_REGS-1:0]             pend,
  input  logic [ADDR_W-1:0]               idx,
  input  logic                            wr_legal,
  input  logic [ADDR_W-1:0]               wr_idx,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [DATA_W-1:0]               data,
  output logic                            hazard
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic w_idx_legal;
  logic w_bypass_hit;

  assign w_idx_legal  = idx_legal(32'(idx), NUM_REGS, ZERO_REG != 0);
  assign w_bypass_hit = (BYPASS != 0) && wr_legal && (wr_idx == idx);

  // A forwarded write both supplies the data and retires the pending producer.
  always_comb begin
    data   = '0;
    hazard = 1'b0;
    if (w_bypass_hit) begin
      data = wr_data;
    end else if (w_idx_legal) begin
      data   = regs[idx[IDX_W-1:0]];
      hazard = pend[idx[IDX_W-1:0]];
    end
  end

endmodule : rf_read_port
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : 2R/1W register file with per-register pending scoreboard.
// Revision : 1.0
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              we,
  input  logic [DATA_W-1:0] i_data,
  input  logic              set_pend,
  input  logic [ADDR_W-1:0] pend_idx,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              any_pend
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [NUM_REGS-1:0]             r_pend;
  logic                            w_wr_legal;
  logic                            w_set_legal;

  // Gating with rst keeps the bypass path from leaking write data during reset.
  assign w_wr_legal  = we && rst && idx_legal(32'(rd), NUM_REGS, ZERO_REG != 0);
  assign w_set_legal = set_pend && idx_legal(32'(pend_idx), NUM_REGS, ZERO_REG != 0);

  // Set is applied after clear so a same-index issue/retire leaves the bit set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regs <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr_legal) begin
        r_regs[rd[IDX_W-1:0]] <= i_data;
        r_pend[rd[IDX_W-1:0]] <= 1'b0;
      end
      if (w_set_legal) begin
        r_pend[pend_idx[IDX_W-1:0]] <= 1'b1;
      end
    end
  end

  assign any_pend = |r_pend;

  rf_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_port_a (
    .regs    (r_regs),
    .pend    (r_pend),
    .idx     (rs),
    .wr_legal(w_wr_legal),
    .wr_idx  (rd),
    .wr_data (i_data),
    .data    (out_data_a),
    .hazard  (hazard_a)
  );

  rf_read_port #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_port_b (
    .regs    (r_regs),
    .pend    (r_pend),
    .idx     (rt),
    .wr_legal(w_wr_legal),
    .wr_idx  (rd),
    .wr_data (i_data),
    .data    (out_data_b),
    .hazard  (hazard_b)
  );

endmodule : regfile_sb
`default_nettype wire
